dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter in front of the data memory / memory-mapped I/O block (address bit 7 selects I/O; the arbiter is address-agnostic). Master 0 is the pipeline MEM stage and master 1 is a secondary requester (program loader / debug port). The arbiter shares the single memory port between them with these properties:
- Master 0 has priority.
- A starvation limit guarantees master 1 progress.
- Master 1 can lock the port for a bounded burst.
- Synchronous read data is routed back to the master that issued the read.

## Interface
- STARVE_MAX, 4: consecutive cycles master 1 may wait before it overrides master 0 (1–15).
- BURST_MAX, 8: maximum consecutive beats in one locked master-1 burst (2–15).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_gnt  out  1  master 0 access performed this cycle (combinational)
- m0_rvalid  out  1  master 0 read data valid (registered)
- m0_rdata  out  32  master 0 read data
- cpu_stall  out  1  m0_req & ~m0_gnt
- m1_req, m1_we, m1_lock  in  1  master 1 request, write, burst lock
- m1_addr, m1_wdata  in  32  master 1 address / write data
- m1_gnt, m1_rvalid  out  1  as for master 0
- m1_rdata  out  32  master 1 read data
- mem_addr, mem_datain  out  32  to memory port
- mem_we  out  1  memory write enable
- mem_dataout  in  32  memory/I-O read data (valid the cycle after the address edge)
- arb_state  out  2  current FSM state, for debug

## Operation
- Grant rules by state (FSM states are ARB=0, BURST=1, COOL=2):
  - ARB: grant m0 if m0_req, unless starved (wait_cnt == STARVE_MAX) and m1_req, in which case grant m1. Otherwise grant m1 if m1_req.
  - BURST: grant m1 if m1_req, else grant m0 if m0_req.
  - COOL: grant m0 if m0_req; m1 is never granted.
- At most one grant per cycle.
- mem_addr/mem_datain come from the granted master; with no grant they carry m0 values.
- mem_we = granted master's we; 0 with no grant.
- Transitions:
  - ARB→BURST: m1 granted with m1_lock=1; beat_cnt←1.
  - BURST, m1 granted with m1_lock=1 and beat_cnt+1 < BURST_MAX: stay in BURST, beat_cnt++.
  - BURST, m1 granted with m1_lock=0, or beat_cnt+1 == BURST_MAX: go to COOL.
  - BURST, m1_req=0: go to ARB. m0 may be granted that same cycle.
  - COOL→ARB unconditionally after 1 cycle.
- Starvation counter wait_cnt (4 bits):
  - Increments while m1_req & ~m1_gnt, saturating at STARVE_MAX.
  - Clears when m1 is granted or m1_req=0.
- Read return:
  - rsel/rpend registers capture the granted master and ~we at each edge.
  - mX_rvalid = rpend & (rsel==X).
  - mX_rdata = mem_dataout when mX_rvalid, else 0.
- Writes produce no response.
- Requesters must hold req/we/addr/wdata stable until their gnt is seen.

## Timing
- Grant is combinational: the access occurs at the rising edge ending the grant cycle.
- Read latency is 1 cycle: rvalid and rdata are asserted in the cycle after the grant.
- Back-to-back grants every cycle are allowed, including alternating masters.
- Reset values: state=ARB, wait_cnt=0, beat_cnt=0, rpend=0, rsel=0, all rvalid=0, all rdata=0.
- Combinational outputs follow inputs immediately after reset deassertion.
- Reset mid-burst or mid-read: the pending read is dropped and no rvalid follows. The memory write in progress at the edge is not cancelled.
- Both masters requesting in ARB with wait_cnt < STARVE_MAX: m0 wins.

## Test plan
- Only m0 reads address 0x04 at cycle 1 -> m0_gnt=1 in cycle 1; m0_rvalid=1 with m0_rdata=mem[1] in cycle 2; cpu_stall=0 throughout.
- m0 and m1 both request continuously in ARB, STARVE_MAX=4 -> m0 granted cycles 0–3; m1 granted cycle 4 with cpu_stall=1; wait_cnt=0 at cycle 5.
- m1 locked write burst with m1_lock=1 for 10 beats, BURST_MAX=8, m0 requesting -> m1 granted 8 consecutive cycles; then COOL with m0 granted; m1 resumes in ARB only via starvation.
- m1 read granted at cycle n, m0 read granted at n+1 -> m1_rvalid only at n+1, m0_rvalid only at n+2, each with its own mem_dataout.
- resetn asserted low mid-burst, one cycle after an m1 read grant -> arb_state=0, m1_rvalid=0 immediately; after release m0 request is granted in the first cycle.
- I/O write from m0 to 0x80 with data 0x55 -> mem_we=1, mem_addr=0x80, mem_datain=0x55 for one cycle; no rvalid.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory / memory-mapped I/O port
// between the pipeline MEM stage (master 0) and a secondary requester
// (master 1: program loader / debug port).
//
// Master 0 normally wins. Master 1 is protected by a starvation counter,
// and it can hold the port for a bounded locked burst. A short cool-down
// state after each burst hands master 0 at least one cycle.
//
// Read data returns one cycle after the grant. It is steered to the master
// that issued the read.
//
// Ports
//   clock, resetn              rising-edge clock, asynchronous active-low reset
//   m0_req/we/addr/wdata       master 0 request
//   m0_gnt                     master 0 access performed this cycle (comb.)
//   m0_rvalid/m0_rdata         master 0 read return (one cycle after grant)
//   cpu_stall                  m0_req & ~m0_gnt
//   m1_req/we/lock/addr/wdata  master 1 request (lock holds a burst)
//   m1_gnt/m1_rvalid/m1_rdata  as for master 0
//   mem_addr/mem_datain/mem_we shared memory port, driven by the granted master
//   mem_dataout                read data, valid the cycle after the address edge
//   arb_state                  FSM state for debug (ARB=0, BURST=1, COOL=2)
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        cpu_stall,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_COOL  = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [4:0] BURST_LIM  = 5'(BURST_MAX);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        rsel_q, rsel_d;
    logic        rpend_q, rpend_d;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        starved_s;
    logic        mem_we_s;

    assign starved_s = (wait_cnt_q == STARVE_LIM);

    // Grant selection by state; at most one of gnt0_s/gnt1_s is ever set
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (m1_req && starved_s) begin
                    gnt1_s = 1'b1;
                end else if (m0_req) begin
                    gnt0_s = 1'b1;
                end else if (m1_req) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt1_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (m1_req) begin
                    gnt1_s = 1'b1;
                end else if (m0_req) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                end
            end
            default: begin
                // COOL, and the unused encoding: master 1 is locked out
                if (m0_req) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                end
            end
        endcase
    end

    // Next-state, burst beat counting and starvation counting
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (gnt1_s && m1_lock) begin
                    state_d    = ST_BURST;
                    beat_cnt_d = 4'd1;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_BURST: begin
                // In BURST a pending m1 request is always the one granted
                if (!m1_req) begin
                    state_d    = ST_ARB;
                    beat_cnt_d = 4'd0;
                end else if (m1_lock && (({1'b0, beat_cnt_q} + 5'd1) < BURST_LIM)) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end else begin
                    state_d    = ST_COOL;
                    beat_cnt_d = 4'd0;
                end
            end
            ST_COOL: begin
                state_d = ST_ARB;
            end
            default: begin
                state_d    = ST_ARB;
                beat_cnt_d = 4'd0;
            end
        endcase

        if (m1_req && !gnt1_s) begin
            wait_cnt_d = starved_s ? wait_cnt_q : (wait_cnt_q + 4'd1);
        end else begin
            wait_cnt_d = 4'd0;
        end
    end

    // Memory port mux: with no grant the bus idles on master 0's values
    always_comb begin
        if (gnt1_s) begin
            mem_addr   = m1_addr;
            mem_datain = m1_wdata;
            mem_we_s   = m1_we;
        end else begin
            mem_addr   = m0_addr;
            mem_datain = m0_wdata;
            mem_we_s   = gnt0_s & m0_we;
        end
        rsel_d  = gnt1_s;
        rpend_d = (gnt0_s | gnt1_s) & ~mem_we_s;
    end

    // Arbiter state and read-return tracking registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= 4'd0;
            beat_cnt_q <= 4'd0;
            rsel_q     <= 1'b0;
            rpend_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            rsel_q     <= rsel_d;
            rpend_q    <= rpend_d;
        end
    end

    assign mem_we    = mem_we_s;
    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign cpu_stall = m0_req & ~gnt0_s;
    assign arb_state = state_q;

    // Return data is forced to zero for the master not being answered
    assign m0_rvalid = rpend_q & ~rsel_q;
    assign m1_rvalid = rpend_q & rsel_q;
    assign m0_rdata  = m0_rvalid ? mem_dataout : 32'd0;
    assign m1_rdata  = m1_rvalid ? mem_dataout : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic        m0_gnt, m0_rvalid, cpu_stall;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout = 32'd0;
    logic [1:0]  arb_state;

    dmem_arbiter #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
        .clock(clock), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .cpu_stall(cpu_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
        .mem_dataout(mem_dataout), .arb_state(arb_state)
    );

    always #5 clock = ~clock;

    // Behavioural synchronous memory: mem[i] preloaded with 0xA000_0000 + i
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    end
    always @(posedge clock) begin
        mem_dataout <= mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] <= mem_datain;
    end

    typedef struct {
        logic [8:0]  v;      // {g0,g1,stall,we,rv0,rv1,state[1:0],rdata_leak}
        logic        cb;
        logic [31:0] addr;
        logic [31:0] wdata;
        string       name;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] rq0 [$];
    logic [31:0] rq1 [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        done = 1'b0;

    task automatic drv(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic step(input logic g0, input logic g1, input logic st_l, input logic we,
                        input logic rv0, input logic rv1, input logic [1:0] st,
                        input logic cb, input logic [31:0] ea, input logic [31:0] ed,
                        input string nm);
        exp_t e;
        e.v = {g0, g1, st_l, we, rv0, rv1, st, 1'b0};
        e.cb = cb; e.addr = ea; e.wdata = ed; e.name = nm;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops expectations each cycle and matches read returns
    always @(negedge clock) begin
        exp_t        e;
        logic [8:0]  act;
        logic [31:0] w;
        logic        leak;
        leak = (~m0_rvalid & (|m0_rdata)) | (~m1_rvalid & (|m1_rdata));
        act  = {m0_gnt, m1_gnt, cpu_stall, mem_we, m0_rvalid, m1_rvalid, arb_state, leak};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (act !== e.v) begin
                n_err++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.v);
            end
            if (e.cb) begin
                n_vec++;
                if ({mem_addr, mem_datain} !== {e.addr, e.wdata}) begin
                    n_err++;
                    $display("FAIL %s bus: got %h/%h want %h/%h", e.name, mem_addr, mem_datain, e.addr, e.wdata);
                end
            end
        end
        if (m0_rvalid) begin
            n_vec++;
            if (rq0.size() == 0) begin
                n_err++;
                $display("FAIL m0_rdata: unexpected rvalid, data %h", m0_rdata);
            end else begin
                w = rq0.pop_front();
                if (m0_rdata !== w) begin
                    n_err++;
                    $display("FAIL m0_rdata: got %h want %h", m0_rdata, w);
                end
            end
        end
        if (m1_rvalid) begin
            n_vec++;
            if (rq1.size() == 0) begin
                n_err++;
                $display("FAIL m1_rdata: unexpected rvalid, data %h", m1_rdata);
            end else begin
                w = rq1.pop_front();
                if (m1_rdata !== w) begin
                    n_err++;
                    $display("FAIL m1_rdata: got %h want %h", m1_rdata, w);
                end
            end
        end
        if (done) begin
            n_vec++;
            if (rq0.size() + rq1.size() + exp_q.size() != 0) begin
                n_err++;
                $display("FAIL drain: got %0d/%0d/%0d outstanding want 0", rq0.size(), rq1.size(), exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        logic [19:0] g1_mask;
        logic        g0e, g1e, p0, p1;
        logic [1:0]  ste;
        int          k;

        @(posedge clock);
        #1;
        // Reset state
        drv(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "reset0");
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "reset1");
        resetn = 1'b1;

        // Single m0 read of 0x04
        drv(1, 0, 32'h04, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        rq0.push_back(32'hA000_0001);
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b1, 32'h04, 32'd0, "m0_rd_gnt");
        drv(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 1, 0, 2'd0, 1'b0, 32'd0, 32'd0, "m0_rd_ret");

        // I/O write from m0
        drv(1, 1, 32'h80, 32'h55, 0, 0, 0, 32'd0, 32'd0);
        step(1, 0, 0, 1, 0, 0, 2'd0, 1'b1, 32'h80, 32'h55, "io_wr");
        drv(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "io_wr_norv");

        // Both masters reading continuously: m1 wins on starvation at 4 and 9
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            g1e = (c == 4) || (c == 9);
            g0e = (c < 10) && !g1e;
            drv(c < 10, 0, 32'h08, 32'd0, c < 10, 0, 0, 32'h0C, 32'd0);
            if (g0e) rq0.push_back(32'hA000_0002);
            if (g1e) rq1.push_back(32'hA000_0003);
            step(g0e, g1e, g1e, 0, p0, p1, 2'd0, 1'b0, 32'd0, 32'd0, "starve");
            p0 = g0e; p1 = g1e;
        end

        // Locked write burst of 10 beats with m0 reading throughout
        g1_mask = 20'h30FF0;
        k = 0;
        p0 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            g1e = g1_mask[c];
            g0e = (c < 19) && !g1e;
            if (((c >= 5) && (c <= 11)) || (c == 17) || (c == 18)) ste = 2'd1;
            else if (c == 12) ste = 2'd2;
            else ste = 2'd0;
            drv(c < 19, 0, 32'h10, 32'd0, k < 10, 1, 1,
                32'h100 + 32'(k) * 32'd4, 32'hB0 + 32'(k));
            if (g0e) rq0.push_back(32'hA000_0004);
            step(g0e, g1e, g1e, g1e, p0, 0, ste, c == 4, 32'h100, 32'hB0, "burst");
            if (g1e) k++;
            p0 = g0e;
        end

        // m1 read then m0 read on consecutive cycles
        drv(0, 0, 32'd0, 32'd0, 1, 0, 0, 32'h14, 32'd0);
        rq1.push_back(32'hA000_0005);
        step(0, 1, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "alt_m1");
        drv(1, 0, 32'h18, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        rq0.push_back(32'hA000_0006);
        step(1, 0, 0, 0, 0, 1, 2'd0, 1'b0, 32'd0, 32'd0, "alt_m0");
        drv(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 1, 0, 2'd0, 1'b0, 32'd0, 32'd0, "alt_ret");

        // Reset mid-burst, one cycle after an m1 read grant
        drv(0, 0, 32'd0, 32'd0, 1, 0, 1, 32'h1C, 32'd0);
        rq1.push_back(32'hA000_0007);
        step(0, 1, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "rst_b0");
        drv(0, 0, 32'd0, 32'd0, 1, 0, 1, 32'h20, 32'd0);
        step(0, 1, 0, 0, 0, 1, 2'd1, 1'b0, 32'd0, 32'd0, "rst_b1");
        resetn = 1'b0;
        drv(1, 0, 32'h24, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "rst_mid");
        resetn = 1'b1;
        rq0.push_back(32'hA000_0009);
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, "rst_rel");
        drv(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 1, 0, 2'd0, 1'b0, 32'd0, 32'd0, "rst_ret");

        done = 1'b1;
    end

endmodule
